// File: rtl/exe_stage_pkg.sv
// Shared definitions for the LA32 execute stage: bus widths, ALU op bit positions, bus payload layouts.
package exe_stage_pkg;

  localparam int unsigned DS_TO_ES_BUS_WD = 151;
  localparam int unsigned ES_TO_MS_BUS_WD = 71;
  localparam int unsigned ALU_OP_WD       = 12;

  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 load_op;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 gr_we;
    logic                 mem_we;
    logic [4:0]           dest;
    logic [31:0]          imm;
    logic [31:0]          rj_value;
    logic [31:0]          rkd_value;
    logic [31:0]          pc;
    logic                 res_from_mem;
  } ds_to_es_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

endpackage

// File: rtl/exe_stage_alu.sv
// One-hot ALU for the execute stage; shift amount is src2[4:0], lui passes src2 through.
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [ALU_OP_WD-1:0] alu_op,
  input  logic [31:0]          alu_src1,
  input  logic [31:0]          alu_src2,
  output logic [31:0]          alu_result
);

  logic [31:0] sra_result;
  logic        slt_bit;
  logic        sltu_bit;

  assign sra_result = 32'($signed(alu_src1) >>> alu_src2[4:0]);
  assign slt_bit    = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_bit   = alu_src1 < alu_src2;

  always_comb begin
    alu_result = '0;
    if (alu_op[ALU_ADD])  alu_result = alu_result | (alu_src1 + alu_src2);
    if (alu_op[ALU_SUB])  alu_result = alu_result | (alu_src1 - alu_src2);
    if (alu_op[ALU_SLT])  alu_result = alu_result | {31'd0, slt_bit};
    if (alu_op[ALU_SLTU]) alu_result = alu_result | {31'd0, sltu_bit};
    if (alu_op[ALU_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
    if (alu_op[ALU_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
    if (alu_op[ALU_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
    if (alu_op[ALU_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
    if (alu_op[ALU_SLL])  alu_result = alu_result | (alu_src1 << alu_src2[4:0]);
    if (alu_op[ALU_SRL])  alu_result = alu_result | (alu_src1 >> alu_src2[4:0]);
    if (alu_op[ALU_SRA])  alu_result = alu_result | sra_result;
    if (alu_op[ALU_LUI])  alu_result = alu_result | alu_src2;
  end

endmodule

// File: rtl/exe_stage.sv
// LA32 execute stage: latches the ID bundle, computes the ALU result, issues one data-SRAM
// request per ld.w/st.w and hands the result bundle to MEM under valid/allowin.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [4:0]                 es_to_ds_dest,
  output logic                       es_to_ds_load_op,
  output logic [31:0]                es_to_ds_result,
  output logic                       data_sram_req,
  output logic                       data_sram_wr,
  output logic [1:0]                 data_sram_size,
  output logic [3:0]                 data_sram_wstrb,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  input  logic                       data_sram_addr_ok
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SENT = 1'b1;

  logic        es_valid;
  ds_to_es_t   es_bus;
  es_to_ms_t   ms_payload;
  logic [0:0]  addr_acc_r;
  logic [0:0]  addr_acc_nxt;
  logic        mem_op;
  logic        es_ready_go;
  logic        ms_handshake;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  end

  // Bundle register carries no reset: es_valid qualifies every use of it.
  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) es_bus <= ds_to_es_t'(ds_to_es_bus);
  end

  assign alu_src1 = es_bus.src1_is_pc  ? es_bus.pc  : es_bus.rj_value;
  assign alu_src2 = es_bus.src2_is_imm ? es_bus.imm : es_bus.rkd_value;

  exe_stage_alu u_alu (
    .alu_op     (es_bus.alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result)
  );

  assign mem_op       = es_bus.load_op | es_bus.mem_we;
  assign es_ready_go  = ~mem_op | (addr_acc_r == SENT) | (data_sram_req & data_sram_addr_ok);
  assign es_allowin   = ~es_valid | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid & es_ready_go;
  assign ms_handshake = es_to_ms_valid & ms_allowin;

  // Request tracking: remembers an accepted address until the instruction leaves for MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr_acc_r <= IDLE;
    else       addr_acc_r <= addr_acc_nxt;
  end

  always_comb begin
    addr_acc_nxt = addr_acc_r;
    if (ms_handshake)                            addr_acc_nxt = IDLE;
    else if (data_sram_req && data_sram_addr_ok) addr_acc_nxt = SENT;
  end

  // Never request unless MEM can take the instruction that owns the response.
  assign data_sram_req   = es_valid & mem_op & (addr_acc_r == IDLE) & ms_allowin;
  assign data_sram_wr    = es_bus.mem_we;
  assign data_sram_size  = SRAM_SIZE_WORD;
  assign data_sram_wstrb = es_bus.mem_we ? 4'hf : 4'h0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus.rkd_value;

  assign es_to_ds_dest    = (es_valid & es_bus.gr_we) ? es_bus.dest : 5'd0;
  assign es_to_ds_load_op = es_valid & es_bus.res_from_mem;
  assign es_to_ds_result  = alu_result;

  always_comb begin
    ms_payload.res_from_mem = es_bus.res_from_mem;
    ms_payload.gr_we        = es_bus.gr_we;
    ms_payload.dest         = es_bus.dest;
    ms_payload.alu_result   = alu_result;
    ms_payload.pc           = es_bus.pc;
  end

  assign es_to_ms_bus = ms_payload;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus a randomized stream against a reference model.
module tb_exe_stage;

  typedef struct {
    logic [11:0] op;
    logic        load_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [31:0] pc;
    logic        rfm;
  } instr_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [150:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [4:0]   es_to_ds_dest;
  logic         es_to_ds_load_op;
  logic [31:0]  es_to_ds_result;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [1:0]   data_sram_size;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;

  int n_pass  = 0;
  int n_total = 0;

  exe_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_allowin        (es_allowin),
    .ds_to_es_valid    (ds_to_es_valid),
    .ds_to_es_bus      (ds_to_es_bus),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_to_ds_dest     (es_to_ds_dest),
    .es_to_ds_load_op  (es_to_ds_load_op),
    .es_to_ds_result   (es_to_ds_result),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [150:0] pack(input instr_t i);
    return {i.op, i.load_op, i.src1_is_pc, i.src2_is_imm, i.gr_we, i.mem_we,
            i.dest, i.imm, i.rj, i.rkd, i.pc, i.rfm};
  endfunction

  // Reference ALU: op bits in order add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui.
  function automatic logic [31:0] ref_result(input instr_t i);
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    a  = i.src1_is_pc ? i.pc : i.rj;
    b  = i.src2_is_imm ? i.imm : i.rkd;
    sh = b[4:0];
    case (i.op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12'h008: return (a < b) ? 32'd1 : 32'd0;
      12'h010: return a & b;
      12'h020: return ~(a | b);
      12'h040: return a | b;
      12'h080: return a ^ b;
      12'h100: return a << sh;
      12'h200: return a >> sh;
      12'h400: return $unsigned($signed(a) >>> sh);
      12'h800: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [70:0] exp_bus(input instr_t i);
    return {i.rfm, i.gr_we, i.dest, ref_result(i), i.pc};
  endfunction

  function automatic instr_t mk_alu(input logic [11:0] op, input logic [31:0] rj, input logic [31:0] rkd,
                                    input logic [4:0] dest, input logic gr_we);
    instr_t i;
    i.op = op; i.load_op = 1'b0; i.src1_is_pc = 1'b0; i.src2_is_imm = 1'b0;
    i.gr_we = gr_we; i.mem_we = 1'b0; i.dest = dest; i.imm = 32'd0;
    i.rj = rj; i.rkd = rkd; i.pc = 32'h1c00_0000 + {rj[7:0], 2'b00}; i.rfm = 1'b0;
    return i;
  endfunction

  function automatic instr_t mk_mem(input logic store, input logic [31:0] rj, input logic [31:0] imm,
                                    input logic [31:0] rkd, input logic [4:0] dest, input logic [31:0] pc);
    instr_t i;
    i.op = 12'h001; i.load_op = ~store; i.src1_is_pc = 1'b0; i.src2_is_imm = 1'b1;
    i.gr_we = ~store; i.mem_we = store; i.dest = dest; i.imm = imm;
    i.rj = rj; i.rkd = rkd; i.pc = pc; i.rfm = ~store;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int kind;
    kind = $urandom_range(0, 3);
    if (kind == 0) begin
      i = mk_mem($urandom_range(0, 1) == 1, $urandom, $urandom & 32'hfff, $urandom,
                 5'($urandom_range(0, 31)), $urandom);
    end else begin
      i = mk_alu(12'(1 << $urandom_range(0, 11)), $urandom, $urandom,
                 5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
      i.src1_is_pc  = $urandom_range(0, 1) == 1;
      i.src2_is_imm = $urandom_range(0, 1) == 1;
      i.imm         = $urandom;
      i.pc          = $urandom;
    end
    return i;
  endfunction

  // Drives one cycle of inputs after the falling edge, then waits 1ns so outputs can be sampled.
  task automatic step(input logic v, input instr_t i, input logic allow, input logic ok);
    @(negedge clk);
    ds_to_es_valid    = v;
    ds_to_es_bus      = pack(i);
    ms_allowin        = allow;
    data_sram_addr_ok = ok;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ds_to_es_valid = 1'b0; ms_allowin = 1'b1; data_sram_addr_ok = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0; ms_allowin = 1'b0; data_sram_addr_ok = 1'b0;
    #2;
    n_total++;
    if ({es_allowin, es_to_ms_valid, data_sram_req, es_to_ds_load_op} !== 4'b1000)
      $display("FAIL reset_ctl got %b want 1000", {es_allowin, es_to_ms_valid, data_sram_req, es_to_ds_load_op});
    else n_pass++;
    n_total++;
    if (es_to_ds_dest !== 5'd0) $display("FAIL reset_dest got %0d want 0", es_to_ds_dest);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    instr_t add_i;
    add_i = mk_alu(12'h001, 32'd5, 32'd7, 5'd3, 1'b1);
    step(1'b1, add_i, 1'b1, 1'b0);
    n_total++;
    if (es_allowin !== 1'b1) $display("FAIL add_allowin got %b want 1", es_allowin); else n_pass++;
    step(1'b0, add_i, 1'b1, 1'b0);
    n_total++;
    if ({es_to_ms_valid, data_sram_req} !== 2'b10)
      $display("FAIL add_valid got %b want 10", {es_to_ms_valid, data_sram_req});
    else n_pass++;
    n_total++;
    if (es_to_ms_bus[63:32] !== 32'd12) $display("FAIL add_result got %0d want 12", es_to_ms_bus[63:32]);
    else n_pass++;
    n_total++;
    if (es_to_ds_dest !== 5'd3) $display("FAIL add_fwd_dest got %0d want 3", es_to_ds_dest); else n_pass++;
    step(1'b0, add_i, 1'b1, 1'b0);
    n_total++;
    if (es_to_ms_valid !== 1'b0) $display("FAIL add_drain got %b want 0", es_to_ms_valid); else n_pass++;
  endtask

  task automatic test_load_stall();
    instr_t ld;
    ld = mk_mem(1'b0, 32'h1000, 32'd8, 32'hdead_beef, 5'd4, 32'h1c00_0100);
    step(1'b1, ld, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, ld, 1'b1, 1'b0);
      n_total++;
      if ({data_sram_req, data_sram_wr, es_allowin, es_to_ms_valid, data_sram_wstrb, data_sram_addr} !==
          {4'b1000, 4'h0, 32'h1008})
        $display("FAIL load_wait%0d got req=%b wr=%b allowin=%b valid=%b wstrb=%h addr=%h want 1 0 0 0 0 00001008",
                 k, data_sram_req, data_sram_wr, es_allowin, es_to_ms_valid, data_sram_wstrb, data_sram_addr);
      else n_pass++;
    end
    n_total++;
    if ({es_to_ds_load_op, es_to_ds_dest, data_sram_size} !== {1'b1, 5'd4, 2'b10})
      $display("FAIL load_fwd got load_op=%b dest=%0d size=%b want 1 4 10",
               es_to_ds_load_op, es_to_ds_dest, data_sram_size);
    else n_pass++;
    step(1'b0, ld, 1'b1, 1'b1);
    n_total++;
    if ({data_sram_req, es_to_ms_valid, es_allowin} !== 3'b111)
      $display("FAIL load_accept got %b want 111", {data_sram_req, es_to_ms_valid, es_allowin});
    else n_pass++;
    step(1'b0, ld, 1'b1, 1'b1);
    n_total++;
    if ({data_sram_req, es_to_ms_valid} !== 2'b00)
      $display("FAIL load_done got %b want 00", {data_sram_req, es_to_ms_valid});
    else n_pass++;
  endtask

  task automatic test_store_allowin();
    instr_t st;
    st = mk_mem(1'b1, 32'h2000, 32'h10, 32'h1234_5678, 5'd9, 32'h1c00_0200);
    step(1'b1, st, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, st, 1'b0, 1'b1);
      n_total++;
      if ({data_sram_req, es_to_ms_valid, es_allowin} !== 3'b000)
        $display("FAIL store_blocked%0d got %b want 000", k, {data_sram_req, es_to_ms_valid, es_allowin});
      else n_pass++;
    end
    step(1'b0, st, 1'b1, 1'b1);
    n_total++;
    if ({data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_wdata, data_sram_addr, es_to_ms_valid} !==
        {2'b11, 4'hf, 32'h1234_5678, 32'h2010, 1'b1})
      $display("FAIL store_req got req=%b wr=%b wstrb=%h wdata=%h addr=%h valid=%b want 1 1 f 12345678 00002010 1",
               data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_wdata, data_sram_addr, es_to_ms_valid);
    else n_pass++;
    n_total++;
    if (es_to_ds_dest !== 5'd0) $display("FAIL store_fwd_dest got %0d want 0", es_to_ds_dest); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, st, 1'b0, 1'b1);
      n_total++;
      if ({data_sram_req, es_to_ms_valid} !== 2'b00)
        $display("FAIL store_no_reissue%0d got %b want 00", k, {data_sram_req, es_to_ms_valid});
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    instr_t beq;
    beq = mk_alu(12'h002, 32'd9, 32'd9, 5'd7, 1'b0);
    step(1'b1, beq, 1'b1, 1'b0);
    step(1'b0, beq, 1'b1, 1'b0);
    n_total++;
    if ({es_to_ds_dest, es_to_ds_load_op, es_to_ms_valid} !== {5'd0, 1'b0, 1'b1})
      $display("FAIL branch_fwd got dest=%0d load_op=%b valid=%b want 0 0 1",
               es_to_ds_dest, es_to_ds_load_op, es_to_ms_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    instr_t l1;
    instr_t l2;
    l1 = mk_mem(1'b0, 32'h3000, 32'h4, 32'd0, 5'd5, 32'h1c00_0300);
    l2 = mk_mem(1'b0, 32'h4000, 32'h8, 32'd0, 5'd6, 32'h1c00_0304);
    step(1'b1, l1, 1'b1, 1'b1);
    step(1'b1, l2, 1'b1, 1'b1);
    n_total++;
    if ({data_sram_req, es_allowin, data_sram_addr} !== {2'b11, 32'h3004})
      $display("FAIL b2b_first got req=%b allowin=%b addr=%h want 1 1 00003004",
               data_sram_req, es_allowin, data_sram_addr);
    else n_pass++;
    step(1'b0, l2, 1'b1, 1'b1);
    n_total++;
    if ({data_sram_req, es_to_ms_valid, data_sram_addr, es_to_ms_bus} !== {2'b11, 32'h4008, exp_bus(l2)})
      $display("FAIL b2b_second got req=%b valid=%b addr=%h bus=%h want 1 1 00004008 %h",
               data_sram_req, es_to_ms_valid, data_sram_addr, es_to_ms_bus, exp_bus(l2));
    else n_pass++;
    step(1'b0, l2, 1'b1, 1'b1);
    n_total++;
    if (data_sram_req !== 1'b0) $display("FAIL b2b_drain got %b want 0", data_sram_req); else n_pass++;
  endtask

  task automatic test_reset_mid_req();
    instr_t ld;
    ld = mk_mem(1'b0, 32'h5000, 32'h0, 32'd0, 5'd2, 32'h1c00_0400);
    step(1'b1, ld, 1'b1, 1'b0);
    step(1'b0, ld, 1'b1, 1'b0);
    n_total++;
    if (data_sram_req !== 1'b1) $display("FAIL rst_mid_pending got %b want 1", data_sram_req); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({data_sram_req, es_to_ms_valid, es_allowin, es_to_ds_load_op} !== 4'b0010)
      $display("FAIL rst_mid_drop got %b want 0010",
               {data_sram_req, es_to_ms_valid, es_allowin, es_to_ds_load_op});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Randomized stream: model tracks the instruction held in EXE and whether its address was accepted.
  task automatic test_random();
    instr_t cur;
    instr_t cand;
    logic   cur_valid;
    logic   accepted;
    logic   cur_mem;
    logic   exp_req;
    logic   exp_done;
    logic   exp_allowin;
    int     retired;
    do_reset();
    cur_valid = 1'b0; accepted = 1'b0; retired = 0;
    cur = mk_alu(12'h001, 32'd0, 32'd0, 5'd0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      cand = rand_instr();
      step($urandom_range(0, 1) == 1, cand, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      cur_mem     = cur_valid && (cur.load_op || cur.mem_we);
      exp_req     = cur_mem && !accepted && ms_allowin;
      exp_done    = cur_valid && (!cur_mem || accepted || (exp_req && data_sram_addr_ok));
      exp_allowin = !cur_valid || (exp_done && ms_allowin);
      n_total++;
      if ({es_allowin, es_to_ms_valid, data_sram_req} !== {exp_allowin, exp_done, exp_req})
        $display("FAIL rnd_ctl c=%0d got %b want %b", c, {es_allowin, es_to_ms_valid, data_sram_req},
                 {exp_allowin, exp_done, exp_req});
      else n_pass++;
      n_total++;
      if ({es_to_ds_dest, es_to_ds_load_op} !==
          (cur_valid ? {(cur.gr_we ? cur.dest : 5'd0), cur.rfm} : 6'd0))
        $display("FAIL rnd_fwd c=%0d got dest=%0d load_op=%b", c, es_to_ds_dest, es_to_ds_load_op);
      else n_pass++;
      if (cur_valid) begin
        n_total++;
        if (es_to_ds_result !== ref_result(cur))
          $display("FAIL rnd_result c=%0d got %h want %h", c, es_to_ds_result, ref_result(cur));
        else n_pass++;
      end
      if (exp_req && data_sram_req) begin
        n_total++;
        if ({data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata} !==
            {cur.mem_we, 2'b10, (cur.mem_we ? 4'hf : 4'h0), ref_result(cur), cur.rkd})
          $display("FAIL rnd_req c=%0d got wr=%b size=%b wstrb=%h addr=%h wdata=%h want addr=%h wdata=%h",
                   c, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata,
                   ref_result(cur), cur.rkd);
        else n_pass++;
      end
      if (exp_done && es_to_ms_valid) begin
        n_total++;
        if (es_to_ms_bus !== exp_bus(cur))
          $display("FAIL rnd_bus c=%0d got %h want %h", c, es_to_ms_bus, exp_bus(cur));
        else n_pass++;
      end
      if (exp_req && data_sram_addr_ok) accepted = 1'b1;
      if (exp_done && ms_allowin) begin
        cur_valid = 1'b0;
        retired++;
      end
      if (ds_to_es_valid && exp_allowin) begin
        cur = cand; cur_valid = 1'b1; accepted = 1'b0;
      end
    end
    n_total++;
    if (retired < 50) $display("FAIL rnd_progress got %0d retired want >= 50", retired); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_stall();
    test_store_allowin();
    test_branch();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
